// File: rtl/dmux16_pkg.sv
// dmux16_pkg: shared FIFO state encoding, select constants and next-state helper.
package dmux16_pkg;
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  typedef logic [1:0] fifo_state_t;
  function automatic fifo_state_t next_state(input fifo_state_t s, input logic push, input logic pop);
    return (push && !pop) ? ((s == EMPTY) ? ONE : FULL) :
           (pop && !push) ? ((s == FULL) ? ONE : EMPTY) : s;
  endfunction
endpackage

// File: rtl/dmux16_fifo2.sv
// dmux16_fifo2: two-entry FIFO, head always in r_mem0 so the output is a plain register.
module dmux16_fifo2
  import dmux16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output fifo_state_t      o_state
);
  fifo_state_t      r_state;
  logic [WIDTH-1:0] r_mem0, r_mem1;
  logic             w_push, w_pop;
  assign w_push = i_push && (r_state != FULL);
  assign w_pop  = i_pop && (r_state != EMPTY);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_mem0  <= '0;
      r_mem1  <= '0;
    end else begin
      r_state <= next_state(r_state, w_push, w_pop);
      if (w_pop && r_state == FULL) r_mem0 <= r_mem1;
      // a push lands at the head when it will be the only entry left
      if (w_push && (r_state == EMPTY || (r_state == ONE && w_pop))) r_mem0 <= i_data;
      else if (w_push) r_mem1 <= i_data;
    end
  end
  assign o_data  = r_mem0;
  assign o_full  = (r_state == FULL);
  assign o_empty = (r_state == EMPTY);
  assign o_state = r_state;
endmodule

// File: rtl/dmux16_stream.sv
// dmux16_stream: routes a valid/ready stream to channel a or b through per-channel 2-entry FIFOs.
// Optional per-channel delivery counters when DMUX16_STREAM_CNT_EN is defined.
module dmux16_stream
  import dmux16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready
`ifdef DMUX16_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
`endif
);
  logic        w_a_full, w_a_empty, w_b_full, w_b_empty;
  logic        w_push_a, w_push_b, w_pop_a, w_pop_b;
  fifo_state_t w_unused_a_state, w_unused_b_state;
  // ready depends only on the selected FIFO, never on in_valid
  assign in_ready = (in_sel == SEL_A) ? !w_a_full : !w_b_full;
  assign w_push_a = in_valid && in_ready && (in_sel == SEL_A);
  assign w_push_b = in_valid && in_ready && (in_sel == SEL_B);
  assign a_valid  = !w_a_empty;
  assign b_valid  = !w_b_empty;
  assign w_pop_a  = a_valid && a_ready;
  assign w_pop_b  = b_valid && b_ready;
  dmux16_fifo2 #(.WIDTH(WIDTH)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .i_push(w_push_a), .i_data(in_data), .i_pop(w_pop_a),
    .o_data(a_data), .o_full(w_a_full), .o_empty(w_a_empty), .o_state(w_unused_a_state)
  );
  dmux16_fifo2 #(.WIDTH(WIDTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .i_push(w_push_b), .i_data(in_data), .i_pop(w_pop_b),
    .o_data(b_data), .o_full(w_b_full), .o_empty(w_b_empty), .o_state(w_unused_b_state)
  );
`ifdef DMUX16_STREAM_CNT_EN
  logic [CNT_W-1:0] r_a_count, r_b_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_count <= '0;
      r_b_count <= '0;
    end else begin
      r_a_count <= r_a_count + CNT_W'(w_pop_a);
      r_b_count <= r_b_count + CNT_W'(w_pop_b);
    end
  end
  assign a_count = r_a_count;
  assign b_count = r_b_count;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif
endmodule

// File: tb/tb_dmux16_stream.sv
// tb_dmux16_stream: vector table, hand-written corner sequences and a queue scoreboard for dmux16_stream.
module tb_dmux16_stream;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data, a_data, b_data;
  logic        in_sel, in_valid, in_ready, a_valid, a_ready, b_valid, b_ready;
  logic [1:0]  a_count, b_count;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  dmux16_stream #(.WIDTH(16), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready)
`ifdef DMUX16_STREAM_CNT_EN
    , .a_count(a_count), .b_count(b_count)
`endif
  );
`ifndef DMUX16_STREAM_CNT_EN
  assign a_count = 2'd0;
  assign b_count = 2'd0;
`endif
  typedef struct {
    logic v; logic sel; logic [15:0] d; logic ar; logic br;
    logic rdy; logic av; logic [15:0] ad; logic bv; logic [15:0] bd;
  } vec_t;
  vec_t tbl[10];
  logic [15:0] qa[$], qb[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic v, input logic s, input logic [15:0] d, input logic ar, input logic br);
    in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [1:0] cnt_seq[5];
    logic [1:0] m_ca, m_cb;
    logic exp_rdy, pa, pb;
    cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    tbl[0] = '{1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h1234};
    tbl[2] = '{1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0};
    tbl[3] = '{1'b1, 1'b1, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h1111};
    tbl[4] = '{1'b1, 1'b1, 16'h3333, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1111};
    tbl[5] = '{1'b1, 1'b0, 16'h9876, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h1111};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h9876, 1'b1, 16'h1111};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h9876, 1'b1, 16'h2222};
    tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h9876, 1'b0, 16'h0};
    tbl[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0};
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", a_valid, 0); chk("rst_b_valid", b_valid, 0);
    chk("rst_a_data", a_data, 0);   chk("rst_b_data", b_data, 0);
    chk("rst_a_count", a_count, 0); chk("rst_b_count", b_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ar, tbl[i].br);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_a_valid", i), a_valid, tbl[i].av);
      chk($sformatf("tbl%0d_b_valid", i), b_valid, tbl[i].bv);
      if (tbl[i].av) chk($sformatf("tbl%0d_a_data", i), a_data, tbl[i].ad);
      if (tbl[i].bv) chk($sformatf("tbl%0d_b_data", i), b_data, tbl[i].bd);
    end
    // order and backpressure on channel a
    @(negedge clk); drive(1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b1);
    @(negedge clk); drive(1'b1, 1'b0, 16'h5555, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    #1 chk("bp_a_data0", a_data, 16'hAAAA); chk("bp_full_ready", in_ready, 0);
    @(negedge clk); #1 chk("bp_a_hold", a_data, 16'hAAAA); chk("bp_a_valid", a_valid, 1);
    @(negedge clk); a_ready = 1'b1;
    #1 chk("bp_a_first", a_data, 16'hAAAA);
    @(negedge clk); #1 chk("bp_a_second", a_data, 16'h5555); chk("bp_a_valid2", a_valid, 1);
    @(negedge clk); #1 chk("bp_a_drained", a_valid, 0);
    // asynchronous reset while channel b is FULL
    @(negedge clk); drive(1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    @(negedge clk); drive(1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
    #1 chk("mr_b_full", in_ready, 0);
    #1 rst_n = 1'b0;
    #1 chk("mr_b_valid", b_valid, 0); chk("mr_b_data", b_data, 0); chk("mr_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1 chk($sformatf("mr_post%0d_b_valid", i), b_valid, 0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(1'b1, 1'b0, 16'(i + 16'h100), 1'b1, 1'b1);
      @(negedge clk); drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      #1 chk($sformatf("cnt%0d_a_data", i), a_data, 16'(i + 16'h100));
      @(negedge clk); #1;
`ifdef DMUX16_STREAM_CNT_EN
      chk($sformatf("cnt%0d_a_count", i), a_count, cnt_seq[i]);
      chk($sformatf("cnt%0d_b_count", i), b_count, 0);
`else
      chk($sformatf("cnt%0d_a_valid", i), a_valid, 0);
`endif
    end
`ifdef DMUX16_STREAM_CNT_EN
    m_ca = 2'd1;
`else
    m_ca = 2'd0;
`endif
    m_cb = 2'd0;
    qa = {}; qb = {};
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 16'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
      #1;
      exp_rdy = (in_sel ? qb.size() : qa.size()) < 2;
      chk("sb_in_ready", in_ready, exp_rdy);
      chk("sb_a_valid", a_valid, qa.size() != 0);
      chk("sb_b_valid", b_valid, qb.size() != 0);
      if (qa.size() != 0) chk("sb_a_data", a_data, qa[0]);
      if (qb.size() != 0) chk("sb_b_data", b_data, qb[0]);
`ifdef DMUX16_STREAM_CNT_EN
      chk("sb_a_count", a_count, m_ca);
      chk("sb_b_count", b_count, m_cb);
`endif
      pa = (qa.size() != 0) && a_ready;
      pb = (qb.size() != 0) && b_ready;
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      m_ca = m_ca + 2'(pa);
      m_cb = m_cb + 2'(pb);
      if (in_valid && exp_rdy) begin
        if (in_sel) qb.push_back(in_data);
        else qa.push_back(in_data);
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
